button_conditioner: RTL and testbench

Front-end stage between the physical call panels and the elevator controller. It synchronises and debounces all 30 raw button inputs: 12 hall buttons and 9 car buttons per car. It then emits a one-clock "new press" pulse per button on the `newRealFloorButton` / `newInternalButton1` / `newInternalButton2` buses the controller consumes. A press is suppressed when the controller already reports that button lit, so duplicate requests never reach the dispatcher.

---
 rtl/button_conditioner_pkg.sv | 14 +
 rtl/button_conditioner_debounce_cell.sv | 61 ++++++
 rtl/button_conditioner.sv | 61 ++++++
 tb/tb_button_conditioner.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared button-bus geometry for the call-panel front end and the elevator controller.
package button_conditioner_pkg;

    localparam int FLOOR_W     = 12;
    localparam int INT_LO      = 1;
    localparam int INT_HI      = 9;
    localparam int INT_W       = INT_HI - INT_LO + 1;
    localparam int NUM_BUTTONS = FLOOR_W + 2 * INT_W;

    typedef logic [FLOOR_W-1:0]     floorBus_t;
    typedef logic [INT_HI:INT_LO]   carBus_t;
    typedef logic [NUM_BUTTONS-1:0] buttonVec_t;

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One button: two-flop synchroniser, sample-counting debouncer and press-pulse register.
module debounce_cell #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    input  logic lit,
    output logic newPress
);

    localparam int CW = $clog2(STABLE_SAMPLES + 1);

    logic          s1_r;
    logic          s2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          newPress_r;
    logic          stableNext_s;
    logic [CW-1:0] cntNext_s;

    // Next debounced level and sample count, evaluated only on prescaler ticks.
    always_comb begin
        stableNext_s = stable_r;
        cntNext_s    = cnt_r;
        if (tick) begin
            if (s2_r == stable_r) begin
                cntNext_s = {CW{1'b0}};
            end else if ((cnt_r + CW'(1)) == CW'(STABLE_SAMPLES)) begin
                stableNext_s = s2_r;
                cntNext_s    = {CW{1'b0}};
            end else begin
                cntNext_s = cnt_r + CW'(1);
            end
        end else begin
            stableNext_s = stable_r;
            cntNext_s    = cnt_r;
        end
    end

    // Synchroniser, debounce state and pulse register; a lit button swallows its press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r       <= 1'b0;
            s2_r       <= 1'b0;
            stable_r   <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            newPress_r <= 1'b0;
        end else begin
            s1_r       <= raw;
            s2_r       <= s1_r;
            stable_r   <= stableNext_s;
            cnt_r      <= cntNext_s;
            newPress_r <= stableNext_s & ~stable_r & ~lit;
        end
    end

    assign newPress = newPress_r;

endmodule

// File: rtl/button_conditioner.sv
// Conditions all hall and car buttons into one-clock new-press pulses for the controller.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLK_PER_SAMPLE = 4,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FLOOR_W-1:0]   rawFloorButton,
    input  logic [INT_HI:INT_LO] rawInternalButton1,
    input  logic [INT_HI:INT_LO] rawInternalButton2,
    input  logic [FLOOR_W-1:0]   currentRealFloorButton,
    input  logic [INT_HI:INT_LO] currentInternalButton1,
    input  logic [INT_HI:INT_LO] currentInternalButton2,
    output logic [FLOOR_W-1:0]   newRealFloorButton,
    output logic [INT_HI:INT_LO] newInternalButton1,
    output logic [INT_HI:INT_LO] newInternalButton2
);

    localparam int PW = $clog2(CLK_PER_SAMPLE + 1);

    logic [PW-1:0] presc_r;
    logic          tick_s;
    buttonVec_t    rawAll_s;
    buttonVec_t    litAll_s;
    buttonVec_t    newAll_s;

    assign tick_s = (presc_r == PW'(CLK_PER_SAMPLE - 1));

    // Shared sample prescaler, wrapping on the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Flatten all buses to one vector: hall buttons in the low bits, car 2 on top.
    assign rawAll_s = {rawInternalButton2, rawInternalButton1, rawFloorButton};
    assign litAll_s = {currentInternalButton2, currentInternalButton1, currentRealFloorButton};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gCell
        debounce_cell #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) uCell (
            .clk      (clk),
            .reset    (reset),
            .raw      (rawAll_s[i]),
            .tick     (tick_s),
            .lit      (litAll_s[i]),
            .newPress (newAll_s[i])
        );
    end

    assign {newInternalButton2, newInternalButton1, newRealFloorButton} = newAll_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters (11..14 cycle press latency).
module tb_button_conditioner;

    logic        clk;
    logic        reset;
    logic [11:0] rawFloorButton;
    logic [9:1]  rawInternalButton1;
    logic [9:1]  rawInternalButton2;
    logic [11:0] currentRealFloorButton;
    logic [9:1]  currentInternalButton1;
    logic [9:1]  currentInternalButton2;
    logic [11:0] newRealFloorButton;
    logic [9:1]  newInternalButton1;
    logic [9:1]  newInternalButton2;

    int checks   = 0;
    int failures = 0;

    button_conditioner dut (
        .clk                    (clk),
        .reset                  (reset),
        .rawFloorButton         (rawFloorButton),
        .rawInternalButton1     (rawInternalButton1),
        .rawInternalButton2     (rawInternalButton2),
        .currentRealFloorButton (currentRealFloorButton),
        .currentInternalButton1 (currentInternalButton1),
        .currentInternalButton2 (currentInternalButton2),
        .newRealFloorButton     (newRealFloorButton),
        .newInternalButton1     (newInternalButton1),
        .newInternalButton2     (newInternalButton2)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({newRealFloorButton, newInternalButton1, newInternalButton2} !== 30'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {newRealFloorButton, newInternalButton1, newInternalButton2});
        end
        reset = 1'b1;
        idle(5);
    endtask

    task automatic test_clean_press;
        int first = -1;
        int pulses = 0;
        int other = 0;
        logic [11:0] val = 12'h000;
        rawFloorButton[5] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (newRealFloorButton !== 12'h000) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    val = newRealFloorButton;
                end
            end
            if (newInternalButton1 !== 9'h000 || newInternalButton2 !== 9'h000) other++;
        end
        checks++;
        if (val !== 12'h020) begin
            failures++;
            $display("FAIL clean_value got=%h want=020", val);
        end
        checks++;
        if (first < 11 || first > 14) begin
            failures++;
            $display("FAIL clean_latency got=%0d want=11..14", first);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL clean_pulse_count got=%0d want=1", pulses);
        end
        checks++;
        if (other != 0) begin
            failures++;
            $display("FAIL clean_other_buses got=%0d want=0", other);
        end
        rawFloorButton[5] = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            #1;
            if (newRealFloorButton !== 12'h000) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL release_no_pulse got=%0d want=0", pulses);
        end
    endtask

    task automatic test_glitch;
        int pulses = 0;
        for (int c = 0; c < 30; c++) begin
            rawInternalButton1[3] = (c < 6) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            if (newInternalButton1 !== 9'h000) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch_no_pulse got=%0d want=0", pulses);
        end
    endtask

    task automatic test_bounce;
        int first = -1;
        int pulses = 0;
        logic [11:0] val = 12'h000;
        for (int c = 0; c < 40; c++) begin
            rawFloorButton[2] = (c < 4) ? 1'b1 : (c < 8) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (newRealFloorButton !== 12'h000) begin
                pulses++;
                if (first < 0) begin
                    first = c + 1 - 8;
                    val = newRealFloorButton;
                end
            end
        end
        checks++;
        if (pulses != 1 || val !== 12'h004) begin
            failures++;
            $display("FAIL bounce_single_pulse got=%0d/%h want=1/004", pulses, val);
        end
        checks++;
        if (first < 11 || first > 14) begin
            failures++;
            $display("FAIL bounce_latency got=%0d want=11..14", first);
        end
        rawFloorButton[2] = 1'b0;
        idle(25);
    endtask

    task automatic test_masking;
        int first = -1;
        int pulses = 0;
        logic [9:1] val = 9'h000;
        currentInternalButton2[7] = 1'b1;
        rawInternalButton2[7] = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (newInternalButton2 !== 9'h000) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL mask_lit_press got=%0d want=0", pulses);
        end
        currentInternalButton2[7] = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (newInternalButton2 !== 9'h000) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL mask_not_deferred got=%0d want=0", pulses);
        end
        rawInternalButton2[7] = 1'b0;
        idle(25);
        rawInternalButton2[7] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (newInternalButton2 !== 9'h000) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    val = newInternalButton2;
                end
            end
        end
        checks++;
        if (pulses != 1 || val !== 9'h040) begin
            failures++;
            $display("FAIL mask_repress got=%0d/%h want=1/040", pulses, val);
        end
        checks++;
        if (first < 11 || first > 14) begin
            failures++;
            $display("FAIL mask_repress_latency got=%0d want=11..14", first);
        end
        rawInternalButton2[7] = 1'b0;
        idle(25);
    endtask

    task automatic test_simultaneous;
        int first = -1;
        int pulses = 0;
        logic [29:0] val = 30'h0;
        rawFloorButton     = 12'hfff;
        rawInternalButton1 = 9'h1ff;
        rawInternalButton2 = 9'h1ff;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if ({newRealFloorButton, newInternalButton1, newInternalButton2} !== 30'h0) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    val = {newRealFloorButton, newInternalButton1, newInternalButton2};
                end
            end
        end
        checks++;
        if (val !== 30'h3fffffff) begin
            failures++;
            $display("FAIL simultaneous_value got=%h want=3fffffff", val);
        end
        checks++;
        if (pulses != 1 || first < 11 || first > 14) begin
            failures++;
            $display("FAIL simultaneous_timing got=%0d@%0d want=1@11..14", pulses, first);
        end
        rawFloorButton     = 12'h000;
        rawInternalButton1 = 9'h000;
        rawInternalButton2 = 9'h000;
        idle(25);
    endtask

    task automatic test_reset_mid;
        int first = -1;
        int pulses = 0;
        logic [20:0] val = 21'h0;
        rawFloorButton[0] = 1'b1;
        rawInternalButton1[9] = 1'b1;
        idle(5);
        reset = 1'b0;
        #1;
        checks++;
        if ({newRealFloorButton, newInternalButton1, newInternalButton2} !== 30'h0) begin
            failures++;
            $display("FAIL reset_mid_debounce got=%h want=0",
                     {newRealFloorButton, newInternalButton1, newInternalButton2});
        end
        idle(3);
        reset = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if ({newRealFloorButton, newInternalButton1} !== 21'h0) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    val = {newRealFloorButton, newInternalButton1};
                    reset = 1'b0;
                    #1;
                    checks++;
                    if ({newRealFloorButton, newInternalButton1, newInternalButton2} !== 30'h0) begin
                        failures++;
                        $display("FAIL reset_async_clear got=%h want=0",
                                 {newRealFloorButton, newInternalButton1, newInternalButton2});
                    end
                end
            end
        end
        checks++;
        if (val !== {12'h001, 9'h100} || pulses != 1) begin
            failures++;
            $display("FAIL reset_release_press got=%0d/%h want=1/%h", pulses, val, {12'h001, 9'h100});
        end
        checks++;
        if (first < 11 || first > 14) begin
            failures++;
            $display("FAIL reset_release_latency got=%0d want=11..14", first);
        end
        rawFloorButton[0] = 1'b0;
        rawInternalButton1[9] = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(5);
    endtask

    initial begin
        clk                    = 1'b0;
        reset                  = 1'b0;
        rawFloorButton         = 12'h000;
        rawInternalButton1     = 9'h000;
        rawInternalButton2     = 9'h000;
        currentRealFloorButton = 12'h000;
        currentInternalButton1 = 9'h000;
        currentInternalButton2 = 9'h000;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_masking();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
